// File: rtl/s_ram_pkg.sv
// Shared types and defaults for the S-memory arbiter: widths, FSM states, requester indices.
package s_ram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic REQ_ENGINE = 1'b0;
    localparam logic REQ_HOST   = 1'b1;

endpackage

// File: rtl/s_ram_arbiter_if.sv
// Requester, ramcore and status signals between the S-memory arbiter and its environment.
interface s_ram_arbiter_if
    import s_ram_pkg::*;
#(
    parameter int ADDR_W = s_ram_pkg::ADDR_W,
    parameter int DATA_W = s_ram_pkg::DATA_W
);
    logic              req0, lock0, we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0, rvalid0;

    logic              req1, lock1, we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1, rvalid1;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    logic              lock_err;

    // Arbiter side
    modport slave (
        input  req0, lock0, we0, addr0, wdata0,
        input  req1, lock1, we1, addr1, wdata1,
        input  ram_q,
        output gnt0, rvalid0, gnt1, rvalid1,
        output rdata, ram_addr, ram_data, ram_wren, lock_err
    );

    // Requesters plus ramcore side
    modport master (
        output req0, lock0, we0, addr0, wdata0,
        output req1, lock1, we1, addr1, wdata1,
        output ram_q,
        input  gnt0, rvalid0, gnt1, rvalid1,
        input  rdata, ram_addr, ram_data, ram_wren, lock_err
    );

endinterface

// File: rtl/s_ram_arbiter.sv
// Round-robin arbiter with ownership lock in front of the 256x8 S ramcore.
// Optional lock watchdog: define S_RAM_ARB_LOCK_TIMEOUT_EN.
module s_ram_arbiter
    import s_ram_pkg::*;
#(
    parameter int ADDR_W   = s_ram_pkg::ADDR_W,
    parameter int DATA_W   = s_ram_pkg::DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic            clk,
    input  logic            reset,
    s_ram_arbiter_if.slave  bus
);

    arb_state_t        r_state;
    logic              r_last;
    logic              r_rvalid0, r_rvalid1;
    logic              w_gnt0, w_gnt1;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Grant is same-cycle; a lock owner is served alone, otherwise the non-last winner takes ties.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            ARB: begin
                w_gnt0 = bus.req0 & (~bus.req1 | (r_last == REQ_HOST));
                w_gnt1 = bus.req1 & (~bus.req0 | (r_last == REQ_ENGINE));
            end
            LOCK0:   w_gnt0 = bus.req0;
            LOCK1:   w_gnt1 = bus.req1;
            default: ;
        endcase
    end

    assign w_addr = w_gnt1 ? bus.addr1  : bus.addr0;
    assign w_data = w_gnt1 ? bus.wdata1 : bus.wdata0;

    assign bus.gnt0     = w_gnt0;
    assign bus.gnt1     = w_gnt1;
    assign bus.ram_addr = w_addr;
    assign bus.ram_data = w_data;
    assign bus.ram_wren = (w_gnt0 & bus.we0) | (w_gnt1 & bus.we1);
    assign bus.rvalid0  = r_rvalid0;
    assign bus.rvalid1  = r_rvalid1;
    assign bus.rdata    = bus.ram_q;

`ifdef S_RAM_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_lock_err;
    logic             w_timeout;

    // Fires on the LOCK_MAX-th locked cycle if the owner still asserts its lock.
    assign w_timeout = ((r_state == LOCK0 && bus.lock0) || (r_state == LOCK1 && bus.lock1)) &&
                       (r_lock_cnt == CNT_W'(LOCK_MAX - 1));
    assign bus.lock_err = r_lock_err;
`else
    logic w_unused_lock_max;
    assign w_unused_lock_max = |LOCK_MAX;
    assign bus.lock_err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ARB;
            r_last    <= REQ_HOST;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
`ifdef S_RAM_ARB_LOCK_TIMEOUT_EN
            r_lock_cnt <= '0;
            r_lock_err <= 1'b0;
`endif
        end else begin
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;

            if (w_gnt0)
                r_last <= REQ_ENGINE;
            else if (w_gnt1)
                r_last <= REQ_HOST;

            case (r_state)
                ARB: begin
                    if (w_gnt0 && bus.lock0)
                        r_state <= LOCK0;
                    else if (w_gnt1 && bus.lock1)
                        r_state <= LOCK1;
                end
                LOCK0:   if (!bus.lock0) r_state <= ARB;
                LOCK1:   if (!bus.lock1) r_state <= ARB;
                default: r_state <= ARB;
            endcase

`ifdef S_RAM_ARB_LOCK_TIMEOUT_EN
            // Counter is cleared in every ARB cycle, so each lock period starts from zero.
            if (r_state == ARB) begin
                r_lock_cnt <= '0;
            end else if (w_timeout) begin
                r_state    <= ARB;
                r_lock_err <= 1'b1;
                r_lock_cnt <= '0;
            end else begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_s_ram_arbiter.sv
// Bench for s_ram_arbiter: directed vector table, reset/timeout sequences, random traffic vs. model.
module tb_s_ram_arbiter;
    import s_ram_pkg::*;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LMAX = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    s_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    s_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Ramcore stand-in: read-before-write, one-cycle q latency
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (bus.ram_wren) ram[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= ram[bus.ram_addr];
    end

    typedef struct {
        logic       r0, l0, w0;
        logic [7:0] a0, d0;
        logic       r1, l1, w1;
        logic [7:0] a1, d1;
    } req_t;

    typedef struct {
        req_t       in;
        logic       g0, g1, v0, v1;
        logic [7:0] rd;
    } vec_t;

    // Reference model: owner of the memory (-1 = none), last served requester, shadow memory
    int         m_owner, m_last, m_cnt;
    bit         m_err;
    bit         m_pv [2];
    logic [7:0] m_pd [2];
    logic [7:0] m_mem [256];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic req_t mk(input logic r0, l0, w0, input logic [7:0] a0, d0,
                                input logic r1, l1, w1, input logic [7:0] a1, d1);
        req_t r;
        r.r0 = r0; r.l0 = l0; r.w0 = w0; r.a0 = a0; r.d0 = d0;
        r.r1 = r1; r.l1 = l1; r.w1 = w1; r.a1 = a1; r.d1 = d1;
        return r;
    endfunction

    function automatic vec_t mv(input req_t r, input logic g0, g1, v0, v1, input logic [7:0] rd);
        vec_t v;
        v.in = r; v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_cnt = 0; m_err = 0;
        m_pv[0] = 0; m_pv[1] = 0;
    endtask

    task automatic apply(input req_t r);
        bus.req0 = r.r0; bus.lock0 = r.l0; bus.we0 = r.w0; bus.addr0 = r.a0; bus.wdata0 = r.d0;
        bus.req1 = r.r1; bus.lock1 = r.l1; bus.we1 = r.w1; bus.addr1 = r.a1; bus.wdata1 = r.d1;
    endtask

    // One clock: drive, sample at negedge against the model, advance the model, pass the edge.
    task automatic step(input req_t r, output logic ag0, ag1, av0, av1, output logic [7:0] ard);
        int win, old;
        bit lk, wr;
        logic [7:0] a, d;
        apply(r);
        @(negedge clk);
        ag0 = bus.gnt0; ag1 = bus.gnt1; av0 = bus.rvalid0; av1 = bus.rvalid1; ard = bus.rdata;

        if (m_owner < 0) begin
            if (r.r0 && r.r1) win = (m_last == 0) ? 1 : 0;
            else if (r.r0)    win = 0;
            else if (r.r1)    win = 1;
            else              win = -1;
        end else begin
            win = ((m_owner == 0) ? r.r0 : r.r1) ? m_owner : -1;
        end
        wr = (win == 0) ? r.w0 : (win == 1) ? r.w1 : 1'b0;
        a  = (win == 1) ? r.a1 : r.a0;
        d  = (win == 1) ? r.d1 : r.d0;

        chk("gnt0", bus.gnt0, win == 0);
        chk("gnt1", bus.gnt1, win == 1);
        chk("rvalid0", bus.rvalid0, m_pv[0]);
        chk("rvalid1", bus.rvalid1, m_pv[1]);
        if (m_pv[0]) chk("rdata0", bus.rdata, m_pd[0]);
        if (m_pv[1]) chk("rdata1", bus.rdata, m_pd[1]);
        chk("ram_wren", bus.ram_wren, wr);
        chk("ram_addr", bus.ram_addr, a);
        if (wr) chk("ram_data", bus.ram_data, d);
        chk("lock_err", bus.lock_err, m_err);

        m_pv[0] = 0; m_pv[1] = 0;
        if (win >= 0) begin
            if (wr) m_mem[a] = d;
            else begin m_pv[win] = 1; m_pd[win] = m_mem[a]; end
            m_last = win;
        end
        old = m_owner;
        if (old < 0) begin
            m_cnt = 0;
            if (win >= 0 && ((win == 0) ? r.l0 : r.l1)) m_owner = win;
        end else begin
            lk = (old == 0) ? r.l0 : r.l1;
            m_cnt++;
            if (!lk) m_owner = -1;
`ifdef S_RAM_ARB_LOCK_TIMEOUT_EN
            else if (m_cnt == LMAX) begin m_owner = -1; m_err = 1; end
`endif
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic regen(input int who, inout req_t r);
        if (who == 0) begin
            r.r0 = ($urandom_range(3) != 0); r.l0 = ($urandom_range(4) == 0); r.w0 = $urandom_range(1);
            r.a0 = 8'($urandom_range(15)); r.d0 = 8'($urandom);
        end else begin
            r.r1 = ($urandom_range(3) != 0); r.l1 = ($urandom_range(4) == 0); r.w1 = $urandom_range(1);
            r.a1 = 8'($urandom_range(15)); r.d1 = 8'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [$];
        req_t       idle, br, cur;
        logic       g0, g1, v0, v1;
        logic [7:0] rd;
        int         first_g1;

        for (int i = 0; i < 256; i++) begin
            ram[i]   = 8'(i) ^ 8'h5A;
            m_mem[i] = 8'(i) ^ 8'h5A;
        end
        ram[5]   = 8'hA7;
        m_mem[5] = 8'hA7;

        idle = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00);
        apply(idle);
        reset = 1'b1;
        model_reset();
        #1;
        chk("reset_gnt0", bus.gnt0, 0);
        chk("reset_rvalid0", bus.rvalid0, 0);
        chk("reset_rvalid1", bus.rvalid1, 0);
        chk("reset_lock_err", bus.lock_err, 0);
        chk("reset_wren", bus.ram_wren, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // single read, alternating ties, locked swap with host waiting
        br = mk(1,0,0,8'h01,8'h00, 1,0,0,8'h02,8'h00);
        tbl.push_back(mv(mk(1,0,0,8'h05,8'h00, 0,0,0,8'h00,8'h00), 1,0,0,0,8'h00));
        tbl.push_back(mv(idle,                                     0,0,1,0,8'hA7));
        tbl.push_back(mv(mk(0,0,0,8'h00,8'h00, 1,0,0,8'h06,8'h00), 0,1,0,0,8'h00));
        tbl.push_back(mv(br,                                       1,0,0,1,8'h5C));
        tbl.push_back(mv(br,                                       0,1,1,0,8'h5B));
        tbl.push_back(mv(br,                                       1,0,0,1,8'h58));
        tbl.push_back(mv(br,                                       0,1,1,0,8'h5B));
        tbl.push_back(mv(idle,                                     0,0,0,1,8'h58));
        tbl.push_back(mv(mk(1,1,0,8'h10,8'h00, 1,0,0,8'h30,8'h00), 1,0,0,0,8'h00));
        tbl.push_back(mv(mk(1,1,0,8'h20,8'h00, 1,0,0,8'h30,8'h00), 1,0,1,0,8'h4A));
        tbl.push_back(mv(mk(1,1,1,8'h10,8'h33, 1,0,0,8'h30,8'h00), 1,0,1,0,8'h7A));
        tbl.push_back(mv(mk(1,0,1,8'h20,8'h44, 1,0,0,8'h30,8'h00), 1,0,0,0,8'h00));
        tbl.push_back(mv(mk(0,0,0,8'h00,8'h00, 1,0,0,8'h30,8'h00), 0,1,0,0,8'h00));
        tbl.push_back(mv(mk(1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00), 1,0,0,1,8'h6A));
        tbl.push_back(mv(mk(0,0,0,8'h00,8'h00, 1,0,0,8'h20,8'h00), 0,1,1,0,8'h33));
        tbl.push_back(mv(idle,                                     0,0,0,1,8'h44));

        foreach (tbl[i]) begin
            step(tbl[i].in, g0, g1, v0, v1, rd);
            chk($sformatf("tbl%0d_gnt0", i), g0, tbl[i].g0);
            chk($sformatf("tbl%0d_gnt1", i), g1, tbl[i].g1);
            chk($sformatf("tbl%0d_rvalid0", i), v0, tbl[i].v0);
            chk($sformatf("tbl%0d_rvalid1", i), v1, tbl[i].v1);
            if (tbl[i].v0 || tbl[i].v1) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
        end

        // reset one cycle after a granted read: read dropped, tie restarts at requester 0
        step(mk(1,0,0,8'h40,8'h00, 0,0,0,8'h00,8'h00), g0, g1, v0, v1, rd);
        chk("pre_rst_gnt0", g0, 1);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_drop_rvalid0", bus.rvalid0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(br, g0, g1, v0, v1, rd);
        chk("rst_tie_gnt0", g0, 1);
        chk("rst_tie_gnt1", g1, 0);
        chk("rst_tie_rvalid0", v0, 0);
        apply(idle);

        // lock held for 20 cycles while host waits
        do_reset();
        first_g1 = -1;
        for (int i = 0; i < 20; i++) begin
            step(mk(1,1,0,8'h08,8'h00, 1,0,0,8'h09,8'h00), g0, g1, v0, v1, rd);
            if (g1 && first_g1 < 0) first_g1 = i;
        end
`ifdef S_RAM_ARB_LOCK_TIMEOUT_EN
        chk("timeout_first_gnt1", first_g1, LMAX + 1);
        chk("timeout_lock_err", bus.lock_err, 1);
`else
        chk("nolimit_first_gnt1", first_g1, 32'hFFFF_FFFF);
        chk("nolimit_lock_err", bus.lock_err, 0);
`endif
        step(idle, g0, g1, v0, v1, rd);
        step(idle, g0, g1, v0, v1, rd);

        // random traffic; each requester holds its request until granted
        do_reset();
        cur = idle;
        regen(0, cur);
        regen(1, cur);
        for (int i = 0; i < 500; i++) begin
            step(cur, g0, g1, v0, v1, rd);
            if (g0 || !cur.r0) regen(0, cur);
            if (g1 || !cur.r1) regen(1, cur);
        end
        apply(idle);
        step(idle, g0, g1, v0, v1, rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/s_ram_arbiter.md
Name: s_ram_arbiter

Overview:
- Two-requester arbiter for the 256x8 single-port S memory (ramcore instance).
- Shares the memory between the arcfour engine (requester 0) and a host/readout port (requester 1), e.g. a debug dump or message loader.
- Round-robin on conflict; a lock lets a requester keep exclusive ownership across multi-access sequences such as the RC4 read-i/read-j/write-i/write-j swap.
- Returns read data with the ramcore's one-cycle latency.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
LOCK_MAX, 16, maximum consecutive locked cycles before forced release (used only with the optional feature)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high reset
req0  in  1  requester 0 (engine) access request
lock0  in  1  requester 0 holds ownership after this access
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 access accepted this cycle
rvalid0  out  1  requester 0 read data valid
req1, lock1, we1, addr1, wdata1, gnt1, rvalid1  same as above, for requester 1
rdata  out  DATA_W  shared read data (ram_q passthrough); meaningful only when rvalidN=1
ram_addr  out  ADDR_W  to ramcore address
ram_data  out  DATA_W  to ramcore data
ram_wren  out  1  to ramcore wren
ram_q  in  DATA_W  from ramcore q
lock_err  out  1  sticky forced-release flag

Behaviour:
- States: ARB, LOCK0, LOCK1. Registers: state, last_winner, rvalid0/1, lock counter, lock_err.
- Reset (async): state=ARB; last_winner=1, so requester 0 wins the first tie; rvalid0/1=0; lock counter=0; lock_err=0. A pending read in flight at reset is dropped, with no rvalid.
- Grant is combinational, in the same cycle as the request.
  - ARB, one request: that requester is granted.
  - ARB, both request: grant the requester that is not last_winner.
  - ARB, no request: no grant.
  - LOCKn: only requester n can be granted, when reqn=1; the other requester waits with gnt=0.
- Memory port:
  - ram_addr and ram_data come from the granted requester.
  - With no grant, ram_addr holds the requester 0 address and ram_data is don't-care.
  - ram_wren = granted & we of the winner. It is never asserted without a grant.
- Read latency: a granted read in cycle N gives rvalidN=1 in cycle N+1, for one cycle, with rdata=ram_q. A granted write produces no rvalid.
- Back-to-back reads by one requester give a continuous rvalid stream.
- last_winner updates to the granted index on every grant.
- State transitions:
  - ARB -> LOCKn when requester n is granted with lockn=1.
  - LOCKn -> ARB at the end of any cycle where lockn=0. That cycle is still served as locked.
  - A locked requester may idle (reqn=0) while holding the lock.
- Simultaneous request to the same address by both requesters: normal arbitration, no merging.
- A requester must hold req, we, addr and wdata stable until gnt. The arbiter does not latch unaccepted requests.

Optional Feature:
Macro: S_RAM_ARB_LOCK_TIMEOUT_EN
- Defined:
  - The lock counter increments each cycle in LOCKn and clears in ARB.
  - When it reaches LOCK_MAX, the state is forced to ARB, lock_err is set (sticky until reset), and the counter clears.
  - The locking requester cannot re-lock until it is granted again through normal arbitration.
- Not defined: no counter, lock_err tied 0, and the lock is unbounded.

Decomposition:
- Shared package s_ram_pkg:
  - ADDR_W and DATA_W defaults.
  - arb_state_t enum {ARB, LOCK0, LOCK1}.
  - Requester index constants REQ_ENGINE=0, REQ_HOST=1.
- No sub-module: the round-robin pick is two gates, and the FSM stays in one file.

Test Plan:
- Reset, then req0 read addr 0x05 with RAM preloaded 0x05->0xA7 -> gnt0 same cycle, rvalid0=1 next cycle with rdata=0xA7, rvalid1=0.
- req0 and req1 both reading, every cycle for 4 cycles -> grants alternate 0,1,0,1; each rvalid follows its grant by exactly one cycle.
- req0 with lock0=1 doing read 0x10, read 0x20, write 0x10=0x33, write 0x20=0x44 while req1 is held high -> gnt1=0 throughout; gnt1 follows the cycle after lock0 drops; RAM holds 0x33 and 0x44.
- Assert reset in the cycle after a granted read -> rvalid is not asserted, state=ARB, and the next tie goes to requester 0.
- With S_RAM_ARB_LOCK_TIMEOUT_EN and LOCK_MAX=16, lock0 held for 20 cycles with req1 pending -> forced release after 16 locked cycles, lock_err=1, gnt1 follows; without the macro, gnt1 stays 0 and lock_err=0.
